ball_motion: RTL and testbench
==============================

Name: ball_motion

Overview:
- Upstream stage of the 2x2 ball plotter: owns the ball's position and velocity.
- Advances the ball one pixel per axis every SPEED_DIV frame ticks.
- Bounces the ball off the top/bottom walls and both paddles, and pulses a score event on a miss.
- Sequences erase-then-draw requests to the plotter via an enable/done handshake, so the ball is redrawn on the 160x120 framebuffer exactly once per move.

Parameters:
- SCREEN_W, 160, screen width in pixels.
- SCREEN_H, 120, screen height in pixels.
- BALL_SIZE, 2, ball edge length in pixels.
- PADDLE_H, 16, paddle height in pixels.
- LEFT_PADDLE_X, 4, column of the left paddle; paddle is 1 pixel wide.
- RIGHT_PADDLE_X, 155, column of the right paddle; paddle is 1 pixel wide.
- SPEED_DIV, 2, frame ticks per move step (1..15).

Ports:
- clock  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- gameStart  in  1  level; high = play, low = pause.
- frameTick  in  1  one-cycle pulse per video frame.
- leftPaddleY  in  7  top row of the left paddle.
- rightPaddleY  in  7  top row of the right paddle.
- drawDone  in  1  plotter finished the current 2x2 block.
- drawEnable  out  1  level request to the plotter.
- xBall  out  8  ball top-left column.
- yBall  out  7  ball top-left row.
- ballColour  out  3  colour of the current request: 3'b000 erase, 3'b111 draw.
- scoreLeft  out  1  one-cycle pulse: left player scored.
- scoreRight  out  1  one-cycle pulse: right player scored.

Behaviour:
- Reset (resetn low at a clock edge):
  - state = IDLE; xBall = 79; yBall = 59.
  - dx = +1, dy = +1; tick counter = 0; tickPending = 0.
  - drawEnable = 0, ballColour = 0, scoreLeft = scoreRight = 0.
  - Reset wins over every other event, including mid-handshake; drawEnable drops the same edge.
- FSM states: IDLE, DRAW_INIT, WAIT, ERASE, MOVE, DRAW.
- IDLE:
  - Outputs quiet.
  - gameStart = 1 -> DRAW_INIT.
- DRAW_INIT / DRAW / ERASE:
  - drawEnable = 1 with ballColour 7 (DRAW_INIT, DRAW) or 0 (ERASE).
  - xBall/yBall are held stable.
  - Stay until drawDone is sampled 1.
  - Next cycle: drawEnable = 0; DRAW_INIT and DRAW go to WAIT, ERASE goes to MOVE.
  - Minimum one cycle with drawEnable low between consecutive requests.
- Tick counting:
  - Runs in every state except IDLE.
  - Each frameTick increments the counter; reaching SPEED_DIV sets tickPending and clears the counter.
  - Further ticks while tickPending = 1 are dropped (one-deep).
- WAIT:
  - tickPending = 1 and gameStart = 1 -> clear tickPending, go to ERASE.
  - gameStart = 0: hold in WAIT; counting continues, so a pending move fires immediately on resume.
- MOVE (single cycle), evaluated in this order from the current x, y, dx, dy:
  - Vertical:
    - dy = -1 and y = 0 -> dy = +1, y = 1.
    - dy = +1 and y = SCREEN_H-BALL_SIZE -> dy = -1, y = y-1.
    - Otherwise y = y+dy.
  - Paddle overlap: ball rows y..y+1 intersect paddle rows P..P+PADDLE_H-1, i.e. y+1 >= P and y <= P+PADDLE_H-1. Compare in 8-bit unsigned to avoid wrap.
  - Left:
    - dx = -1, x = LEFT_PADDLE_X+1, overlap with leftPaddleY -> dx = +1, x = x+1.
    - dx = -1, x = 0 -> scoreRight pulse, serve.
  - Right:
    - dx = +1, x+BALL_SIZE = RIGHT_PADDLE_X, overlap with rightPaddleY -> dx = -1, x = x-1.
    - dx = +1, x = SCREEN_W-BALL_SIZE -> scoreLeft pulse, serve.
  - Otherwise x = x+dx.
  - Paddle overlap uses the pre-move y.
  - Serve: x = 79, y = 59, dx points toward the conceding player, dy unchanged.
  - Score pulse is asserted for exactly the cycle following MOVE.
  - MOVE -> DRAW.
- Arithmetic: all updates stay within 0..SCREEN_W-2 and 0..SCREEN_H-2. No wrap-around is permitted; the bench asserts this.

Decomposition:
- Shared package pong_pkg:
  - SCREEN_W, SCREEN_H, BALL_SIZE, CENTRE_X = 79, CENTRE_Y = 59.
  - Colour constants COL_BLACK = 3'b000, COL_WHITE = 3'b111.
  - FSM state encoding.
- One sub-module, paddle_hit_check: combinational overlap test (ball y, paddle y, PADDLE_H -> hit). Instantiated twice.

Test Plan:
- Reset then gameStart = 1 -> DRAW_INIT at (79,59), colour 7. Hold drawDone = 1 for one cycle -> drawEnable falls next cycle; state WAIT.
- SPEED_DIV = 2, two frameTicks, drawDone returned 3 cycles after each request:
  - Erase request at (79,59), colour 0.
  - Then draw request at (80,60), colour 7.
- Ball at (10,118), dy = +1, tick -> new y = 117, dy = -1. Ball at y = 0, dy = -1 -> y = 1.
- Ball at (5,40), dx = -1, leftPaddleY = 30 -> x = 6, dx = +1. Same with leftPaddleY = 50 -> ball continues to x = 4; on reaching x = 0 -> scoreRight for 1 cycle, ball redrawn at (79,59), dx = -1.
- Extra frameTicks during a 20-cycle drawDone stall -> exactly one pending move executes afterwards. gameStart = 0 in WAIT -> no requests until gameStart = 1.
- resetn low while drawEnable = 1 in ERASE -> next edge: drawEnable = 0, position (79,59), state IDLE.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants and FSM encoding for the pong ball datapath.
package pong_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int BALL_SIZE = 2;

  localparam logic [7:0] CENTRE_X = 8'd79;
  localparam logic [6:0] CENTRE_Y = 7'd59;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WHITE = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    DRAW_INIT,
    WAIT,
    ERASE,
    MOVE,
    DRAW
  } state_t;

endpackage

// File: rtl/paddle_hit_check.sv
// Combinational row-overlap test between the ball and one paddle.
module paddle_hit_check #(
  parameter int BALL_SIZE = 2,
  parameter int PADDLE_H  = 16
) (
  input  logic [6:0] ballY,
  input  logic [6:0] paddleY,
  output logic       hit
);

  // Widened to 8 bits so bottom edges near row 127 cannot wrap.
  logic [7:0] ballTop;
  logic [7:0] ballBot;
  logic [7:0] padTop;
  logic [7:0] padBot;

  assign ballTop = {1'b0, ballY};
  assign ballBot = {1'b0, ballY} + 8'(BALL_SIZE - 1);
  assign padTop  = {1'b0, paddleY};
  assign padBot  = {1'b0, paddleY} + 8'(PADDLE_H - 1);
  assign hit     = (ballBot >= padTop) && (ballTop <= padBot);

endmodule

// File: rtl/ball_motion.sv
// Ball position/velocity owner: steps on frame ticks, bounces, scores, and
// sequences erase/draw requests to the 2x2 plotter.
module ball_motion #(
  parameter int SCREEN_W       = pong_pkg::SCREEN_W,
  parameter int SCREEN_H       = pong_pkg::SCREEN_H,
  parameter int BALL_SIZE      = pong_pkg::BALL_SIZE,
  parameter int PADDLE_H       = 16,
  parameter int LEFT_PADDLE_X  = 4,
  parameter int RIGHT_PADDLE_X = 155,
  parameter int SPEED_DIV      = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       gameStart,
  input  logic       frameTick,
  input  logic [6:0] leftPaddleY,
  input  logic [6:0] rightPaddleY,
  input  logic       drawDone,
  output logic       drawEnable,
  output logic [7:0] xBall,
  output logic [6:0] yBall,
  output logic [2:0] ballColour,
  output logic       scoreLeft,
  output logic       scoreRight
);

  import pong_pkg::*;

  localparam logic [7:0] X_MAX       = 8'(SCREEN_W - BALL_SIZE);
  localparam logic [6:0] Y_MAX       = 7'(SCREEN_H - BALL_SIZE);
  localparam logic [7:0] X_LEFT_HIT  = 8'(LEFT_PADDLE_X + 1);
  localparam logic [7:0] X_RIGHT_HIT = 8'(RIGHT_PADDLE_X - BALL_SIZE);
  localparam logic [3:0] TICK_LAST   = 4'(SPEED_DIV - 1);

  state_t     state;
  state_t     stateNext;
  logic [7:0] x;
  logic [6:0] y;
  logic       dxNeg;
  logic       dyNeg;
  logic [3:0] tickCnt;
  logic       tickPending;

  logic       hitLeft;
  logic       hitRight;
  logic [7:0] xNext;
  logic [6:0] yNext;
  logic       dxNegNext;
  logic       dyNegNext;
  logic       scoreLNext;
  logic       scoreRNext;

  paddle_hit_check #(.BALL_SIZE(BALL_SIZE), .PADDLE_H(PADDLE_H)) u_hit_left (
    .ballY  (y),
    .paddleY(leftPaddleY),
    .hit    (hitLeft)
  );

  paddle_hit_check #(.BALL_SIZE(BALL_SIZE), .PADDLE_H(PADDLE_H)) u_hit_right (
    .ballY  (y),
    .paddleY(rightPaddleY),
    .hit    (hitRight)
  );

  // Candidate move from the current position; committed only in MOVE.
  always_comb begin
    yNext     = dyNeg ? (y - 7'd1) : (y + 7'd1);
    dyNegNext = dyNeg;
    if (dyNeg && (y == 7'd0)) begin
      dyNegNext = 1'b0;
      yNext     = 7'd1;
    end else if (!dyNeg && (y == Y_MAX)) begin
      dyNegNext = 1'b1;
      yNext     = y - 7'd1;
    end

    xNext      = dxNeg ? (x - 8'd1) : (x + 8'd1);
    dxNegNext  = dxNeg;
    scoreLNext = 1'b0;
    scoreRNext = 1'b0;
    if (dxNeg && (x == X_LEFT_HIT) && hitLeft) begin
      dxNegNext = 1'b0;
      xNext     = x + 8'd1;
    end else if (dxNeg && (x == 8'd0)) begin
      scoreRNext = 1'b1;
      xNext      = CENTRE_X;
      yNext      = CENTRE_Y;
      dxNegNext  = 1'b1;
    end else if (!dxNeg && (x == X_RIGHT_HIT) && hitRight) begin
      dxNegNext = 1'b1;
      xNext     = x - 8'd1;
    end else if (!dxNeg && (x == X_MAX)) begin
      scoreLNext = 1'b1;
      xNext      = CENTRE_X;
      yNext      = CENTRE_Y;
      dxNegNext  = 1'b0;
    end
  end

  always_comb begin
    stateNext  = state;
    drawEnable = 1'b0;
    ballColour = COL_BLACK;
    case (state)
      IDLE: if (gameStart) stateNext = DRAW_INIT;
      DRAW_INIT, DRAW: begin
        drawEnable = 1'b1;
        ballColour = COL_WHITE;
        if (drawDone) stateNext = WAIT;
      end
      ERASE: begin
        drawEnable = 1'b1;
        if (drawDone) stateNext = MOVE;
      end
      WAIT: if (tickPending && gameStart) stateNext = ERASE;
      MOVE: stateNext = DRAW;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      x           <= CENTRE_X;
      y           <= CENTRE_Y;
      dxNeg       <= 1'b0;
      dyNeg       <= 1'b0;
      tickCnt     <= 4'd0;
      tickPending <= 1'b0;
      scoreLeft   <= 1'b0;
      scoreRight  <= 1'b0;
    end else begin
      state      <= stateNext;
      scoreLeft  <= (state == MOVE) && scoreLNext;
      scoreRight <= (state == MOVE) && scoreRNext;
      if (state == MOVE) begin
        x     <= xNext;
        y     <= yNext;
        dxNeg <= dxNegNext;
        dyNeg <= dyNegNext;
      end
      // One-deep tick latch: ticks arriving while a move is pending are lost.
      if ((state == WAIT) && tickPending && gameStart) begin
        tickPending <= 1'b0;
      end else if ((state != IDLE) && frameTick && !tickPending) begin
        if (tickCnt == TICK_LAST) begin
          tickCnt     <= 4'd0;
          tickPending <= 1'b1;
        end else begin
          tickCnt <= tickCnt + 4'd1;
        end
      end
    end
  end

  assign xBall = x;
  assign yBall = y;

endmodule

// File: tb/tb_ball_motion.sv
// Randomized bench for ball_motion against a plain-arithmetic model of the ball rules.
module tb_ball_motion;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       gameStart = 1'b0;
  logic       frameTick = 1'b0;
  logic       drawDone = 1'b0;
  logic [6:0] leftPaddleY = 7'd0;
  logic [6:0] rightPaddleY = 7'd0;
  logic       drawEnable;
  logic [7:0] xBall;
  logic [6:0] yBall;
  logic [2:0] ballColour;
  logic       scoreLeft;
  logic       scoreRight;

  int checks = 0;
  int passes = 0;
  int mx, my, mdx, mdy;
  int scoresSeen = 0;

  ball_motion dut (
    .clock       (clock),
    .resetn      (resetn),
    .gameStart   (gameStart),
    .frameTick   (frameTick),
    .leftPaddleY (leftPaddleY),
    .rightPaddleY(rightPaddleY),
    .drawDone    (drawDone),
    .drawEnable  (drawEnable),
    .xBall       (xBall),
    .yBall       (yBall),
    .ballColour  (ballColour),
    .scoreLeft   (scoreLeft),
    .scoreRight  (scoreRight)
  );

  always #5 clock = ~clock;

  // Position must never leave the visible range.
  always @(negedge clock) begin
    if (resetn === 1'b1) begin
      checks++;
      if (xBall <= 8'd158 && yBall <= 7'd118) passes++;
      else $display("FAIL bounds: got x=%0d y=%0d, required x<=158 y<=118", xBall, yBall);
    end
  end

  task automatic tick();
    @(negedge clock);
    frameTick = 1'b1;
    @(negedge clock);
    frameTick = 1'b0;
  endtask

  // Waits for a request, answers it after lat cycles, optionally pulsing frameTick meanwhile.
  task automatic serve_request(input int lat, input int nticks, output bit ok,
                               output logic [2:0] col, output logic [7:0] x, output logic [6:0] y,
                               output logic sl, output logic sr, output bit stable, output bit dropped);
    ok = 0; col = '0; x = '0; y = '0; sl = 0; sr = 0; stable = 0; dropped = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      if (drawEnable === 1'b1) ok = 1;
    end
    if (!ok) return;
    col = ballColour; x = xBall; y = yBall; sl = scoreLeft; sr = scoreRight;
    stable = 1;
    for (int i = 0; i < lat; i++) begin
      frameTick = (i < nticks);
      @(negedge clock);
      if (drawEnable !== 1'b1 || xBall !== x || yBall !== y) stable = 0;
    end
    frameTick = 1'b0;
    drawDone = 1'b1;
    @(negedge clock);
    drawDone = 1'b0;
    dropped = (drawEnable === 1'b0);
  endtask

  task automatic model_reset();
    mx = 79; my = 59; mdx = 1; mdy = 1;
  endtask

  // Ball rules in plain integer arithmetic.
  task automatic model_move(input int lp, input int rp, output bit sl, output bit sr);
    int nx, ny, ndx, ndy;
    bit hl, hr;
    hl = (my + 1 >= lp) && (my <= lp + 15);
    hr = (my + 1 >= rp) && (my <= rp + 15);
    ndx = mdx; ndy = mdy; sl = 0; sr = 0;
    if (mdy < 0 && my == 0) begin ndy = 1; ny = 1; end
    else if (mdy > 0 && my == 118) begin ndy = -1; ny = my - 1; end
    else ny = my + mdy;
    nx = mx + mdx;
    if (mdx < 0 && mx == 5 && hl) begin ndx = 1; nx = mx + 1; end
    else if (mdx < 0 && mx == 0) begin sr = 1; nx = 79; ny = 59; ndx = -1; end
    else if (mdx > 0 && mx + 2 == 155 && hr) begin ndx = -1; nx = mx - 1; end
    else if (mdx > 0 && mx == 158) begin sl = 1; nx = 79; ny = 59; ndx = 1; end
    mx = nx; my = ny; mdx = ndx; mdy = ndy;
  endtask

  function automatic int pick_paddle(input int y);
    int p;
    if ($urandom_range(0, 1) == 1) begin
      p = y + 1 - int'($urandom_range(0, 16));
      if (p < 0) p = 0;
      if (p > 127) p = 127;
    end else begin
      p = int'($urandom_range(0, 127));
    end
    return p;
  endfunction

  task automatic test_reset();
    resetn = 1'b0; gameStart = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (drawEnable !== 1'b0 || xBall !== 8'd79 || yBall !== 7'd59 || ballColour !== 3'd0 ||
        scoreLeft !== 1'b0 || scoreRight !== 1'b0)
      $display("FAIL reset_state: got en=%0d x=%0d y=%0d col=%0d sl=%0d sr=%0d, required 0/79/59/0/0/0",
               drawEnable, xBall, yBall, ballColour, scoreLeft, scoreRight);
    else passes++;
    resetn = 1'b1;
    // Ticks in IDLE must not accumulate toward a move.
    tick(); tick(); tick();
    repeat (3) @(negedge clock);
    checks++;
    if (drawEnable !== 1'b0) $display("FAIL idle_quiet: got drawEnable=%0d, required 0", drawEnable);
    else passes++;
  endtask

  task automatic test_init_draw();
    bit ok, st, dr; logic [2:0] c; logic [7:0] x; logic [6:0] y; logic sl, sr;
    bit busy;
    gameStart = 1'b1;
    serve_request(0, 0, ok, c, x, y, sl, sr, st, dr);
    checks++;
    if (!ok || c !== 3'd7 || x !== 8'd79 || y !== 7'd59)
      $display("FAIL init_draw: got ok=%0d col=%0d x=%0d y=%0d, required col=7 x=79 y=59", ok, c, x, y);
    else passes++;
    checks++;
    if (!dr) $display("FAIL init_drop: got drawEnable=1 after drawDone, required 0");
    else passes++;
    busy = 0;
    repeat (20) begin
      @(negedge clock);
      if (drawEnable === 1'b1) busy = 1;
    end
    checks++;
    if (busy) $display("FAIL init_wait: got a request with no ticks, required none");
    else passes++;
    model_reset();
  endtask

  task automatic test_play(input int moves);
    bit ok, st, dr, esl, esr; logic [2:0] c; logic [7:0] x; logic [6:0] y; logic sl, sr;
    int le, ld;
    for (int m = 0; m < moves; m++) begin
      leftPaddleY  = 7'(pick_paddle(my));
      rightPaddleY = 7'(pick_paddle(my));
      le = (m == 0) ? 3 : int'($urandom_range(0, 4));
      ld = (m == 0) ? 3 : int'($urandom_range(0, 4));
      tick(); tick();
      serve_request(le, 0, ok, c, x, y, sl, sr, st, dr);
      checks++;
      if (!ok || c !== 3'd0 || x !== 8'(mx) || y !== 7'(my))
        $display("FAIL erase_req move %0d: got ok=%0d col=%0d x=%0d y=%0d, required col=0 x=%0d y=%0d",
                 m, ok, c, x, y, mx, my);
      else passes++;
      checks++;
      if (!st || !dr) $display("FAIL erase_hs move %0d: got stable=%0d dropped=%0d, required 1/1", m, st, dr);
      else passes++;
      model_move(int'(leftPaddleY), int'(rightPaddleY), esl, esr);
      serve_request(ld, 0, ok, c, x, y, sl, sr, st, dr);
      checks++;
      if (!ok || c !== 3'd7 || x !== 8'(mx) || y !== 7'(my))
        $display("FAIL draw_req move %0d: got ok=%0d col=%0d x=%0d y=%0d, required col=7 x=%0d y=%0d",
                 m, ok, c, x, y, mx, my);
      else passes++;
      checks++;
      if (sl !== esl || sr !== esr)
        $display("FAIL score move %0d: got sl=%0d sr=%0d, required sl=%0d sr=%0d", m, sl, sr, esl, esr);
      else passes++;
      if (esl || esr) scoresSeen++;
      checks++;
      if (!st || !dr) $display("FAIL draw_hs move %0d: got stable=%0d dropped=%0d, required 1/1", m, st, dr);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok, st, dr, esl, esr; logic [2:0] c; logic [7:0] x; logic [6:0] y; logic sl, sr;
    bit busy;
    tick(); tick();
    serve_request(1, 0, ok, c, x, y, sl, sr, st, dr);
    model_move(int'(leftPaddleY), int'(rightPaddleY), esl, esr);
    // Five ticks during a long draw stall: only one move may be remembered.
    serve_request(20, 5, ok, c, x, y, sl, sr, st, dr);
    checks++;
    if (!ok || c !== 3'd7 || x !== 8'(mx) || y !== 7'(my) || !st)
      $display("FAIL stall_draw: got ok=%0d col=%0d x=%0d y=%0d stable=%0d, required col=7 x=%0d y=%0d",
               ok, c, x, y, st, mx, my);
    else passes++;
    serve_request(2, 0, ok, c, x, y, sl, sr, st, dr);
    checks++;
    if (!ok || c !== 3'd0 || x !== 8'(mx) || y !== 7'(my))
      $display("FAIL pending_erase: got ok=%0d col=%0d x=%0d y=%0d, required col=0 x=%0d y=%0d",
               ok, c, x, y, mx, my);
    else passes++;
    model_move(int'(leftPaddleY), int'(rightPaddleY), esl, esr);
    serve_request(2, 0, ok, c, x, y, sl, sr, st, dr);
    checks++;
    if (!ok || c !== 3'd7 || x !== 8'(mx) || y !== 7'(my))
      $display("FAIL pending_draw: got ok=%0d col=%0d x=%0d y=%0d, required col=7 x=%0d y=%0d",
               ok, c, x, y, mx, my);
    else passes++;
    busy = 0;
    repeat (40) begin
      @(negedge clock);
      if (drawEnable === 1'b1) busy = 1;
    end
    checks++;
    if (busy) $display("FAIL one_deep: got a second pending move, required none");
    else passes++;
  endtask

  task automatic test_pause();
    bit ok, st, dr, esl, esr; logic [2:0] c; logic [7:0] x; logic [6:0] y; logic sl, sr;
    bit busy;
    gameStart = 1'b0;
    tick(); tick();
    busy = 0;
    repeat (30) begin
      @(negedge clock);
      if (drawEnable === 1'b1) busy = 1;
    end
    checks++;
    if (busy) $display("FAIL pause: got a request while paused, required none");
    else passes++;
    gameStart = 1'b1;
    serve_request(1, 0, ok, c, x, y, sl, sr, st, dr);
    checks++;
    if (!ok || c !== 3'd0 || x !== 8'(mx) || y !== 7'(my))
      $display("FAIL resume_erase: got ok=%0d col=%0d x=%0d y=%0d, required col=0 x=%0d y=%0d",
               ok, c, x, y, mx, my);
    else passes++;
    model_move(int'(leftPaddleY), int'(rightPaddleY), esl, esr);
    serve_request(1, 0, ok, c, x, y, sl, sr, st, dr);
    checks++;
    if (!ok || c !== 3'd7 || x !== 8'(mx) || y !== 7'(my))
      $display("FAIL resume_draw: got ok=%0d col=%0d x=%0d y=%0d, required col=7 x=%0d y=%0d",
               ok, c, x, y, mx, my);
    else passes++;
  endtask

  task automatic test_reset_mid_erase();
    bit ok, st, dr, esl, esr; logic [2:0] c; logic [7:0] x; logic [6:0] y; logic sl, sr;
    bit seen, busy;
    tick(); tick();
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (drawEnable === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || ballColour !== 3'd0)
      $display("FAIL mid_erase_req: got seen=%0d col=%0d, required 1/0", seen, ballColour);
    else passes++;
    @(negedge clock);
    resetn = 1'b0; gameStart = 1'b0;
    @(negedge clock);
    checks++;
    if (drawEnable !== 1'b0 || xBall !== 8'd79 || yBall !== 7'd59 || ballColour !== 3'd0)
      $display("FAIL reset_mid: got en=%0d x=%0d y=%0d col=%0d, required 0/79/59/0",
               drawEnable, xBall, yBall, ballColour);
    else passes++;
    resetn = 1'b1;
    busy = 0;
    repeat (5) begin
      @(negedge clock);
      if (drawEnable === 1'b1) busy = 1;
    end
    checks++;
    if (busy) $display("FAIL reset_idle: got a request after reset, required none");
    else passes++;
    gameStart = 1'b1;
    model_reset();
    serve_request(0, 0, ok, c, x, y, sl, sr, st, dr);
    checks++;
    if (!ok || c !== 3'd7 || x !== 8'd79 || y !== 7'd59)
      $display("FAIL reinit_draw: got ok=%0d col=%0d x=%0d y=%0d, required col=7 x=79 y=59", ok, c, x, y);
    else passes++;
    tick(); tick();
    serve_request(3, 0, ok, c, x, y, sl, sr, st, dr);
    model_move(int'(leftPaddleY), int'(rightPaddleY), esl, esr);
    serve_request(3, 0, ok, c, x, y, sl, sr, st, dr);
    checks++;
    if (!ok || c !== 3'd7 || x !== 8'd80 || y !== 7'd60)
      $display("FAIL reinit_move: got ok=%0d col=%0d x=%0d y=%0d, required col=7 x=80 y=60", ok, c, x, y);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_init_draw();
    test_play(1200);
    checks++;
    if (scoresSeen == 0) $display("FAIL score_coverage: got %0d score events, required at least 1", scoresSeen);
    else passes++;
    test_back_to_back();
    test_pause();
    test_reset_mid_erase();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
